mc_controller: RTL

- Multi-cycle successor to the single-cycle MIPS decoder: an FSM that sequences fetch, decode, execute, memory and writeback over several cycles on a shared datapath.
- Memory is single-ported and talks to the FSM through a req/ready handshake.
- Decodes the same instruction subset: lw, sw, R-type ALU ops and shifts, jr, addi, andi, ori, xori, slti, j, jal, beq, bne.
- Adds variable memory wait states, an optional memory timeout and a sticky trap on illegal opcodes.

---
 rtl/mc_controller.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the MIPS subset with a req/ready memory handshake and sticky traps.
// Defining MC_CTRL_PERF_EN adds the cyc_cnt / instr_cnt performance counters.
module mc_controller #(
  parameter int ALU_FUNC_W  = 6,
  parameter int MEM_TIMEOUT = 0,
  parameter int TMR_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            op,
  input  logic [5:0]            func,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  iord,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_src,
  output logic                  reg_we,
  output logic [1:0]            reg_dst,
  output logic [1:0]            wb_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  imm_sext,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  illegal,
  output logic                  timeout,
  output logic [3:0]            state_dbg
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]           cyc_cnt,
  output logic [31:0]           instr_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [TMR_W-1:0] WAIT_MAX  = '1;
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_JAL     = 4'd11,
    S_JR      = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  state_t           state_q, state_d, dec_target;
  logic [TMR_W-1:0] wait_q, wait_d;
  logic             illegal_q, timeout_q;
  logic             mem_state, waiting, tmo_hit;

  always_comb begin
    dec_target = S_TRAP;
    case (op)
      OP_LW, OP_SW:                              dec_target = S_MEMADDR;
      OP_RTYPE:                                  dec_target = (func == FN_JR) ? S_JR : S_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: dec_target = S_EXEC_I;
      OP_BEQ, OP_BNE:                            dec_target = S_BRANCH;
      OP_J:                                      dec_target = S_JUMP;
      OP_JAL:                                    dec_target = S_JAL;
      default:                                   dec_target = S_TRAP;
    endcase
  end

  // The trap fires at the edge ending the MEM_TIMEOUT-th consecutive wait; a late ready still wins.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign waiting   = mem_state && !mem_ready;
  assign tmo_hit   = (MEM_TIMEOUT > 0) && waiting && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE:  state_d = dec_target;
      S_MEMADDR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      default:   state_d = S_TRAP;
    endcase
    if (tmo_hit) state_d = S_TRAP;
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR)))
      wait_d = '0;
    else if (mem_state && mem_ready)
      wait_d = '0;
    else if (waiting && (wait_q != WAIT_MAX))
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if ((state_q == S_DECODE) && (dec_target == S_TRAP)) illegal_q <= 1'b1;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    reg_we    = 1'b0;
    reg_dst   = 2'b00;
    wb_src    = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    imm_sext  = 1'b0;
    alu_func  = ALU_FUNC_W'(FN_ADD);
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        imm_sext  = 1'b1;
      end
      S_MEMADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_sext  = 1'b1;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_we = 1'b1;
        wb_src = 2'b01;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = (func[5:3] == 3'b000) ? 2'b10 : 2'b01;
        alu_func  = ALU_FUNC_W'(func);
        reg_dst   = 2'b01;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (op)
          OP_ANDI: alu_func = ALU_FUNC_W'(FN_AND);
          OP_ORI:  alu_func = ALU_FUNC_W'(FN_OR);
          OP_XORI: alu_func = ALU_FUNC_W'(FN_XOR);
          OP_SLTI: begin
            alu_func = ALU_FUNC_W'(FN_SLT);
            imm_sext = 1'b1;
          end
          default: imm_sext = 1'b1;
        endcase
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = (op == OP_RTYPE) ? 2'b01 : 2'b00;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_func  = ALU_FUNC_W'(FN_SUB);
        pc_src    = 2'b10;
        pc_we     = (op == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'b01;
      end
      S_JAL: begin
        pc_we   = 1'b1;
        pc_src  = 2'b01;
        reg_we  = 1'b1;
        reg_dst = 2'b10;
        wb_src  = 2'b10;
      end
      S_JR: begin
        pc_we  = 1'b1;
        pc_src = 2'b11;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q, instr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) instr_q <= instr_q + 32'd1;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`endif

endmodule
